condicionador_botoes: RTL

Input conditioning stage for the four player buttons of the memory game. It synchronizes and debounces the raw button pins, detects one press per push, and validates that exactly one button was pressed. It then presents a registered one-hot play code with a single-cycle `tem_jogada` strobe to the game datapath, which consumes `jogada`/`tem_jogada` in place of raw `botoes`.

---
 rtl/condicionador_botoes_pkg.sv | 23 ++
 rtl/condicionador_botoes_if.sv | 36 +++
 rtl/condicionador_botoes_debounce_bit.sv | 55 +++++
 rtl/condicionador_botoes.sv | 83 ++++++++
 4 files changed

// File: rtl/condicionador_botoes_pkg.sv
// condicionador_pkg: shared definitions for the button conditioning block.
//   NUM_BOTOES  - number of player buttons handled by the block
//   estado_t    - press-tracking FSM state (OCIOSO / PRESSIONADO)
//   is_one_hot  - true when exactly one bit of a button vector is set
package condicionador_pkg;

  localparam int NUM_BOTOES = 4;

  typedef enum logic {
    OCIOSO      = 1'b0,
    PRESSIONADO = 1'b1
  } estado_t;

  function automatic logic is_one_hot(input logic [NUM_BOTOES-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < NUM_BOTOES; i++) begin
      cnt += int'(v[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// condicionador_botoes_if: bundle between the button conditioner and its user.
//   botoes          - raw button pins (user -> conditioner)
//   habilita        - a play is awaited (user -> conditioner)
//   botoes_estaveis - debounced button vector
//   jogada          - last valid one-hot play, held between plays
//   tem_jogada      - one-cycle strobe, a valid play was latched
//   jogada_invalida - one-cycle strobe, a press event was not one-hot
//   db_estado       - press FSM state for observation
//
// Handshake: tem_jogada and jogada_invalida are valid-only strobes with no
// ready; the consumer must accept them on the cycle they are high. jogada is
// valid from the cycle tem_jogada rises and stays valid until the next one.
interface condicionador_botoes_if;
  import condicionador_pkg::*;

  logic [NUM_BOTOES-1:0] botoes;
  logic                  habilita;
  logic [NUM_BOTOES-1:0] botoes_estaveis;
  logic [NUM_BOTOES-1:0] jogada;
  logic                  tem_jogada;
  logic                  jogada_invalida;
  logic                  db_estado;

  // master: the side that owns the pins and consumes the plays
  modport master (
    output botoes, habilita,
    input  botoes_estaveis, jogada, tem_jogada, jogada_invalida, db_estado
  );

  // slave: the conditioner itself
  modport slave (
    input  botoes, habilita,
    output botoes_estaveis, jogada, tem_jogada, jogada_invalida, db_estado
  );

endinterface

// File: rtl/condicionador_botoes_debounce_bit.sv
// debounce_bit: synchronizer plus debounce counter for one button.
//   clock, reset - system clock, asynchronous active-high reset
//   raw          - asynchronous button pin
//   stable       - debounced value
// Macro BOTOES_SINCRONIZADOR_EN: when defined a 2-FF synchronizer sits in
// front of the counter; when undefined the pin feeds the counter directly
// (simulation with synchronous stimulus only).
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          synced;
  logic [CW-1:0] cnt;

`ifdef BOTOES_SINCRONIZADOR_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  assign synced = sync_q[1];
`else
  assign synced = raw;
`endif

  // The counter only runs while the synced value disagrees with the stable
  // one; any agreement restarts it, so short glitches never accumulate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (synced == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= synced;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/condicionador_botoes.sv
// condicionador_botoes: conditions the player buttons into one-hot plays.
//   clock, reset - system clock, asynchronous active-high reset
//   bus (slave)  - botoes/habilita in; botoes_estaveis, jogada, tem_jogada,
//                  jogada_invalida, db_estado out
// Each button is synchronized and debounced independently; a press event is
// the debounced vector leaving 0000 while the FSM is idle. With habilita high
// the event either latches a one-hot play (tem_jogada) or flags an invalid
// multi-button press (jogada_invalida).
// Macro BOTOES_SINCRONIZADOR_EN: enables the 2-FF synchronizers in debounce_bit.
module condicionador_botoes
  import condicionador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  condicionador_botoes_if.slave bus
);

  logic [NUM_BOTOES-1:0] estaveis;
  estado_t               estado;
  logic [NUM_BOTOES-1:0] jogada_q;
  logic                  tem_jogada_q;
  logic                  invalida_q;
  logic                  evento;

  for (genvar i = 0; i < NUM_BOTOES; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock  (clock),
      .reset  (reset),
      .raw    (bus.botoes[i]),
      .stable (estaveis[i])
    );
  end

  // Bits stabilizing together arrive as one multi-bit vector here, which is
  // what makes a simultaneous press a single (invalid) event.
  assign evento = (estado == OCIOSO) && (estaveis != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      jogada_q     <= '0;
      tem_jogada_q <= 1'b0;
      invalida_q   <= 1'b0;
    end else begin
      tem_jogada_q <= 1'b0;
      invalida_q   <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (evento) begin
            // The FSM advances even when habilita is low, so a button held
            // across the rising edge of habilita never produces a strobe.
            estado <= PRESSIONADO;
            if (bus.habilita) begin
              if (is_one_hot(estaveis)) begin
                jogada_q     <= estaveis;
                tem_jogada_q <= 1'b1;
              end else begin
                invalida_q <= 1'b1;
              end
            end
          end
        end
        PRESSIONADO: begin
          if (estaveis == '0) begin
            estado <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign bus.botoes_estaveis = estaveis;
  assign bus.jogada          = jogada_q;
  assign bus.tem_jogada      = tem_jogada_q;
  assign bus.jogada_invalida = invalida_q;
  assign bus.db_estado       = estado;

endmodule
